// File: rtl/cart_header_loader.sv
// cart_header_loader
//   Boot-time sequencer that reads cartridge header bytes HDR_FIRST..HDR_LAST
//   over a request/acknowledge port. It latches the cartridge type and the
//   ROM/RAM size codes and verifies the header checksum. The MBC is held in
//   reset until loading ends.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   mem_adr    header byte address, stable while mem_rd=1
//   mem_rd     read request
//   mem_ack    read acknowledge, mem_data valid in the same cycle
//   mem_data   read data
//   cart_type  header byte 0x0147 (0 until done)
//   rom_size   clamped ROM size code to MBC (0 until done)
//   ram_size   mapped RAM size code to MBC (0 until done)
//   mbc_reset  active-high MBC reset, high while loading
//   done       loading finished (ok or error), sticky until reset
//   hdr_ok     header checksum matched, valid when done=1
//   err        ack timeout occurred
module cart_header_loader #(
    parameter logic [15:0] HDR_FIRST   = 16'h0134,
    parameter logic [15:0] HDR_LAST    = 16'h014D,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_adr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [7:0]  cart_type,
    output logic [2:0]  rom_size,
    output logic [1:0]  ram_size,
    output logic        mbc_reset,
    output logic        done,
    output logic        hdr_ok,
    output logic        err
);

    localparam logic [15:0] CART_TYPE_ADR = 16'h0147;
    localparam logic [15:0] ROM_SIZE_ADR  = 16'h0148;
    localparam logic [15:0] RAM_SIZE_ADR  = 16'h0149;
    localparam logic [9:0]  TMO_LIMIT     = 10'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [7:0]  csum;
    logic [9:0]  tmo_cnt;
    logic [7:0]  cap_type;
    logic [2:0]  cap_rom;
    logic [1:0]  cap_ram;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mem_rd    <= 1'b0;
            mem_adr   <= HDR_FIRST;
            cart_type <= '0;
            rom_size  <= '0;
            ram_size  <= '0;
            mbc_reset <= 1'b1;
            done      <= 1'b0;
            hdr_ok    <= 1'b0;
            err       <= 1'b0;
            csum      <= '0;
            tmo_cnt   <= '0;
            cap_type  <= '0;
            cap_rom   <= '0;
            cap_ram   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= REQ;
                    mem_rd  <= 1'b1;
                    mem_adr <= HDR_FIRST;
                    tmo_cnt <= '0;
                end

                REQ: begin
                    if (mem_ack) begin
                        // Field captures go to shadow registers; outputs
                        // only change once the whole header is in.
                        if (mem_adr == CART_TYPE_ADR)
                            cap_type <= mem_data;
                        if (mem_adr == ROM_SIZE_ADR)
                            cap_rom <= (mem_data <= 8'd6) ? mem_data[2:0] : 3'd6;
                        if (mem_adr == RAM_SIZE_ADR) begin
                            case (mem_data)
                                8'd0:    cap_ram <= 2'd0;
                                8'd1:    cap_ram <= 2'd2;
                                8'd2:    cap_ram <= 2'd2;
                                default: cap_ram <= 2'd3;
                            endcase
                        end

                        mem_rd <= 1'b0;
                        if (mem_adr == HDR_LAST) begin
                            state     <= DONE;
                            hdr_ok    <= (mem_data == csum);
                            done      <= 1'b1;
                            mbc_reset <= 1'b0;
                            cart_type <= cap_type;
                            rom_size  <= cap_rom;
                            ram_size  <= cap_ram;
                        end else begin
                            state <= GAP;
                            csum  <= csum - mem_data - 8'd1;
                        end
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        // Limit reached with no ack: abort with safe defaults.
                        state     <= ERR;
                        mem_rd    <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        hdr_ok    <= 1'b0;
                        mbc_reset <= 1'b0;
                        cart_type <= '0;
                        rom_size  <= '0;
                        ram_size  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end

                GAP: begin
                    state   <= REQ;
                    mem_rd  <= 1'b1;
                    mem_adr <= mem_adr + 16'd1;
                    tmo_cnt <= '0;
                end

                DONE: state <= DONE;

                ERR: state <= ERR;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
